// File: rtl/wb_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_master
// Description : Wishbone classic single-beat master. Takes one read or write
//               request from the memory request arbiter per idle cycle, runs
//               it on the SoC Wishbone fabric and returns registered read data.
//               Optional bus-timeout abort is compiled in with WB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES  max BUS-state cycles before abort (WB_TIMEOUT_EN only),
//                   legal range 1..65535
// Ports
//   clk, nRst                   clock (posedge), async active-low reset
//   mem_read, mem_write         arbiter request strobes (sampled when idle)
//   adr_to_mem, data_to_mem,
//   sel_to_mem                  request address / write data / byte lanes
//   mem_busy                    transaction outstanding
//   data_from_mem               last completed read data
//   timeout_err                 one-cycle pulse on timeout abort
//   CYC_O, STB_O, WE_O, ADR_O,
//   DAT_O, SEL_O                Wishbone master outputs
//   DAT_I, ACK_I, ERR_I         Wishbone slave responses
// Configuration macro
//   WB_TIMEOUT_EN   defined: BUS state aborts after TIMEOUT_CYCLES cycles
//                   undefined: BUS waits indefinitely, timeout_err tied 0
// ============================================================================
module wb_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic [3:0]  sel_to_mem,
  output logic        mem_busy,
  output logic [31:0] data_from_mem,
  output logic        timeout_err,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        ERR_I
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUS  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_req;
  logic        w_timeout;

  assign w_req = mem_read | mem_write;

  // --------------------------------------------------------------------------
  // Optional bus timeout
  // --------------------------------------------------------------------------
`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q;

  // cnt_q holds the number of BUS cycles already elapsed, so the limit is hit
  // during the TIMEOUT_CYCLES-th BUS cycle. ACK/ERR in that cycle take priority.
  assign w_timeout = (state_q == c_ST_BUS) && !ACK_I && !ERR_I &&
                     (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == c_ST_IDLE) begin
      cnt_d = 16'd0;
    end else if (!ACK_I && !ERR_I) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= 16'd0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= w_timeout;
    end
  end

  assign timeout_err = tmo_q;
`else
  logic [15:0] w_unused_timeout;

  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register (also holds the request latches and read data)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= c_ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_req) state_d = c_ST_BUS;
      c_ST_BUS:  if (ACK_I || ERR_I || w_timeout) state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    case (state_q)
      c_ST_IDLE: begin
        // A simultaneous read and write resolves to the write.
        if (w_req) begin
          we_d  = mem_write;
          adr_d = adr_to_mem;
          dat_d = data_to_mem;
          sel_d = sel_to_mem;
        end
      end
      c_ST_BUS: begin
        // ERR beats ACK; ACK beats a timeout in the same cycle.
        if (ERR_I || (!ACK_I && w_timeout)) begin
          if (!we_q) rdata_d = 32'd0;
        end else if (ACK_I) begin
          if (!we_q) rdata_d = DAT_I;
        end
      end
      default: ;
    endcase
  end

  // Bus handshake outputs come straight from the state flop.
  assign mem_busy      = (state_q == c_ST_BUS);
  assign CYC_O         = (state_q == c_ST_BUS);
  assign STB_O         = (state_q == c_ST_BUS);
  assign WE_O          = we_q;
  assign ADR_O         = adr_q;
  assign DAT_O         = dat_q;
  assign SEL_O         = sel_q;
  assign data_from_mem = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_master
// Description : Directed self-checking bench for wb_bus_master. Acts as the
//               arbiter and as a scripted Wishbone slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_master;

  logic        clk;
  logic        nRst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic [3:0]  sel_to_mem;
  logic        mem_busy;
  logic [31:0] data_from_mem;
  logic        timeout_err;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic        ERR_I;

  int n_checks = 0;
  int n_errors = 0;

  wb_bus_master #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .nRst         (nRst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .adr_to_mem   (adr_to_mem),
    .data_to_mem  (data_to_mem),
    .sel_to_mem   (sel_to_mem),
    .mem_busy     (mem_busy),
    .data_from_mem(data_from_mem),
    .timeout_err  (timeout_err),
    .CYC_O        (CYC_O),
    .STB_O        (STB_O),
    .WE_O         (WE_O),
    .ADR_O        (ADR_O),
    .DAT_O        (DAT_O),
    .SEL_O        (SEL_O),
    .DAT_I        (DAT_I),
    .ACK_I        (ACK_I),
    .ERR_I        (ERR_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after this are seen at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- 1: reset ----------------
    nRst        = 1'b0;
    mem_read    = 1'($urandom);
    mem_write   = 1'($urandom);
    adr_to_mem  = $urandom;
    data_to_mem = $urandom;
    sel_to_mem  = 4'($urandom);
    DAT_I       = $urandom;
    ACK_I       = 1'($urandom);
    ERR_I       = 1'($urandom);
    #2;
    check_eq("rst_busy", 32'(mem_busy), 32'd0);
    check_eq("rst_data", data_from_mem, 32'd0);
    check_eq("rst_tmo",  32'(timeout_err), 32'd0);
    check_eq("rst_bus",  {29'd0, CYC_O, STB_O, WE_O}, 32'd0);
    check_eq("rst_adr",  ADR_O, 32'd0);
    check_eq("rst_dat",  DAT_O, 32'd0);
    check_eq("rst_sel",  32'(SEL_O), 32'd0);
    step();
    check_eq("rst_hold_cyc", 32'(CYC_O), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0; ACK_I = 1'b0; ERR_I = 1'b0;
    nRst = 1'b1;
    step(); step(); step();
    check_eq("idle_cyc",  32'(CYC_O), 32'd0);
    check_eq("idle_busy", 32'(mem_busy), 32'd0);

    // ---------------- 2: read, ACK in 3rd bus cycle ----------------
    mem_read = 1'b1; adr_to_mem = 32'h0000_1000; sel_to_mem = 4'hF;
    step();
    mem_read = 1'b0;
    check_eq("rd_cyc1", {30'd0, CYC_O, STB_O}, 32'd3);
    check_eq("rd_busy1", 32'(mem_busy), 32'd1);
    check_eq("rd_we", 32'(WE_O), 32'd0);
    check_eq("rd_adr", ADR_O, 32'h0000_1000);
    check_eq("rd_sel", 32'(SEL_O), 32'hF);
    step();
    check_eq("rd_cyc2", {30'd0, CYC_O, STB_O}, 32'd3);
    step();
    check_eq("rd_cyc3", {30'd0, CYC_O, STB_O}, 32'd3);
    ACK_I = 1'b1; DAT_I = 32'hCAFE_F00D;
    step();
    ACK_I = 1'b0; DAT_I = 32'h0;
    check_eq("rd_done_busy", 32'(mem_busy), 32'd0);
    check_eq("rd_done_cyc", 32'(CYC_O), 32'd0);
    check_eq("rd_data", data_from_mem, 32'hCAFE_F00D);

    // ---------------- 3: write, zero-wait ACK ----------------
    mem_write = 1'b1; adr_to_mem = 32'h0000_2004;
    data_to_mem = 32'h1234_5678; sel_to_mem = 4'h3;
    step();
    mem_write = 1'b0;
    ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
    check_eq("wr_cyc", 32'(CYC_O), 32'd1);
    check_eq("wr_we", 32'(WE_O), 32'd1);
    check_eq("wr_adr", ADR_O, 32'h0000_2004);
    check_eq("wr_dat", DAT_O, 32'h1234_5678);
    check_eq("wr_sel", 32'(SEL_O), 32'h3);
    step();
    ACK_I = 1'b0;
    check_eq("wr_done_busy", 32'(mem_busy), 32'd0);
    check_eq("wr_data_keep", data_from_mem, 32'hCAFE_F00D);

    // ---------------- 4: back-to-back reads, then read+write ----------------
    mem_read = 1'b1; adr_to_mem = 32'h10;
    step();
    check_eq("b2b_adr0", ADR_O, 32'h10);
    ACK_I = 1'b1; DAT_I = 32'h1111_0010;
    step();
    ACK_I = 1'b0; adr_to_mem = 32'h14;
    check_eq("b2b_gap_cyc", 32'(CYC_O), 32'd0);
    check_eq("b2b_data0", data_from_mem, 32'h1111_0010);
    step();
    check_eq("b2b_cyc1", 32'(CYC_O), 32'd1);
    check_eq("b2b_adr1", ADR_O, 32'h14);
    ACK_I = 1'b1; DAT_I = 32'h2222_0014; mem_read = 1'b0;
    step();
    ACK_I = 1'b0;
    check_eq("b2b_data1", data_from_mem, 32'h2222_0014);
    mem_read = 1'b1; mem_write = 1'b1; adr_to_mem = 32'h18; data_to_mem = 32'hA5A5_A5A5;
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    check_eq("both_we", 32'(WE_O), 32'd1);
    check_eq("both_dat", DAT_O, 32'hA5A5_A5A5);
    ACK_I = 1'b1; DAT_I = 32'h9999_9999;
    step();
    ACK_I = 1'b0;
    check_eq("both_data_keep", data_from_mem, 32'h2222_0014);

    // ---------------- 5: ERR on read, ignored responses, reset mid-bus ----------------
    mem_read = 1'b1; adr_to_mem = 32'h20;
    step();
    mem_read = 1'b0;
    ERR_I = 1'b1; DAT_I = 32'h7777_7777;
    step();
    ERR_I = 1'b0;
    check_eq("err_data", data_from_mem, 32'd0);
    check_eq("err_busy", 32'(mem_busy), 32'd0);
    ACK_I = 1'b1; DAT_I = 32'hFFFF_FFFF;
    step();
    ACK_I = 1'b0;
    check_eq("idle_ack_data", data_from_mem, 32'd0);
    check_eq("idle_ack_busy", 32'(mem_busy), 32'd0);
    mem_read = 1'b1; adr_to_mem = 32'h30;
    step();
    mem_read = 1'b0;
    check_eq("mid_cyc", 32'(CYC_O), 32'd1);
    #3;
    nRst = 1'b0;
    #1;
    check_eq("mid_rst_cyc", 32'(CYC_O), 32'd0);
    check_eq("mid_rst_busy", 32'(mem_busy), 32'd0);
    check_eq("mid_rst_adr", ADR_O, 32'd0);
    step();
    nRst = 1'b1;
    step();
    check_eq("post_rst_cyc", 32'(CYC_O), 32'd0);

`ifdef WB_TIMEOUT_EN
    // ---------------- 6: timeout (limit 4) ----------------
    mem_read = 1'b1; adr_to_mem = 32'h40;
    step();
    mem_read = 1'b0;
    ACK_I = 1'b1; DAT_I = 32'h5555_AAAA;
    step();
    ACK_I = 1'b0;
    check_eq("pre_to_data", data_from_mem, 32'h5555_AAAA);
    mem_read = 1'b1; adr_to_mem = 32'h44;
    step();
    mem_read = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("to_cyc%0d", i), {30'd0, CYC_O, timeout_err}, 32'd2);
      step();
    end
    check_eq("to_pulse", 32'(timeout_err), 32'd1);
    check_eq("to_data", data_from_mem, 32'd0);
    check_eq("to_idle", 32'(CYC_O), 32'd0);
    step();
    check_eq("to_pulse_end", 32'(timeout_err), 32'd0);
    mem_read = 1'b1; adr_to_mem = 32'h48;
    step();
    mem_read = 1'b0;
    step(); step(); step();
    check_eq("to_ack_cyc4", 32'(CYC_O), 32'd1);
    ACK_I = 1'b1; DAT_I = 32'h7777_8888;
    step();
    ACK_I = 1'b0;
    check_eq("to_ack_nopulse", 32'(timeout_err), 32'd0);
    check_eq("to_ack_data", data_from_mem, 32'h7777_8888);
    check_eq("to_ack_busy", 32'(mem_busy), 32'd0);
`else
    // ---------------- 6: no timeout build waits indefinitely ----------------
    mem_read = 1'b1; adr_to_mem = 32'h40;
    step();
    mem_read = 1'b0;
    repeat (300) step();
    check_eq("long_wait_cyc", 32'(CYC_O), 32'd1);
    check_eq("long_wait_tmo", 32'(timeout_err), 32'd0);
    ACK_I = 1'b1; DAT_I = 32'h5A5A_0040;
    step();
    ACK_I = 1'b0;
    check_eq("long_wait_data", data_from_mem, 32'h5A5A_0040);
    check_eq("long_wait_busy", 32'(mem_busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
